// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared core package: data width and master tag type
`include "config.svh"

package mem_arbiter_pkg;

  localparam int XLEN = `XLEN;

  // Tag recorded per accepted read so the in-order response can be routed back.
  typedef enum logic {
    MST_IRAM = 1'b0,
    MST_DRAM = 1'b1
  } mst_e;

endpackage

// File: rtl/config.svh
// rtl/config.svh - core-wide build configuration shared by all RTL blocks
`ifndef CONFIG_SVH
`define CONFIG_SVH

// Native data/address width of the core.
`define XLEN 32

`endif

// File: rtl/mem_arbiter_tag_fifo.sv
// rtl/mem_arbiter_tag_fifo.sv - tag FIFO tracking which master owns each outstanding read
//
// Ports:
//   clk, rst_b       clock, synchronous active-low reset (clears count and pointers)
//   push, din        enqueue tag din (caller never pushes when full)
//   pop              dequeue head (caller never pops when empty)
//   full, empty      derived from the registered count only
//   dout             tag at head of queue
module mem_arbiter_tag_fifo
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_b,
  input  logic push,
  input  logic pop,
  input  mst_e din,
  output logic full,
  output logic empty,
  output mst_e dout
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  mst_e           r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign dout  = r_mem[r_rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (push && !pop)      r_count <= r_count + CW'(1);
      else if (pop && !push) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master (iram/dram) arbiter onto one shared RAM port
//
// Build option: MEM_ARBITER_ROUND_ROBIN_EN selects round-robin arbitration;
// otherwise dram has fixed priority over iram.
//
// Ports:
//   clk, rst_b                    clock, synchronous active-low reset
//   iram_* / dram_*               master request (req, write, wstrb, addr, wdata),
//                                 accept (ready) and read response (rvalid, rdata)
//   mem_*                         shared RAM request out, ready/rvalid/rdata in
//   err_rvalid                    sticky: a response arrived with nothing outstanding
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              iram_req,
  input  logic              iram_write,
  input  logic [XLEN/8-1:0] iram_wstrb,
  input  logic [XLEN-1:0]   iram_addr,
  input  logic [XLEN-1:0]   iram_wdata,
  output logic              iram_ready,
  output logic              iram_rvalid,
  output logic [XLEN-1:0]   iram_rdata,
  input  logic              dram_req,
  input  logic              dram_write,
  input  logic [XLEN/8-1:0] dram_wstrb,
  input  logic [XLEN-1:0]   dram_addr,
  input  logic [XLEN-1:0]   dram_wdata,
  output logic              dram_ready,
  output logic              dram_rvalid,
  output logic [XLEN-1:0]   dram_rdata,
  output logic              mem_req,
  output logic              mem_write,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              err_rvalid
);

  logic r_lock;
  mst_e r_lock_mst;
  logic r_err;
  mst_e w_gnt;
  mst_e w_tie;
  mst_e w_head;
  logic w_lock_hold;
  logic w_sel_req;
  logic w_sel_write;
  logic w_fifo_full;
  logic w_fifo_empty;
  logic w_xfer;
  logic w_push;
  logic w_pop;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  mst_e r_prio;

  // Priority flips away from whichever master just transferred.
  always_ff @(posedge clk) begin
    if (!rst_b)      r_prio <= MST_DRAM;
    else if (w_xfer) r_prio <= (w_gnt == MST_DRAM) ? MST_IRAM : MST_DRAM;
  end

  assign w_tie = r_prio;
`else
  assign w_tie = MST_DRAM;
`endif

  // A stalled request keeps its grant until accepted or withdrawn.
  always_comb begin
    w_lock_hold = r_lock && ((r_lock_mst == MST_DRAM) ? dram_req : iram_req);
    w_gnt       = MST_IRAM;
    if (w_lock_hold)              w_gnt = r_lock_mst;
    else if (iram_req && dram_req) w_gnt = w_tie;
    else if (dram_req)             w_gnt = MST_DRAM;
  end

  assign w_sel_req   = (w_gnt == MST_DRAM) ? dram_req   : iram_req;
  assign w_sel_write = (w_gnt == MST_DRAM) ? dram_write : iram_write;
  assign mem_write   = w_sel_write;
  assign mem_wstrb   = (w_gnt == MST_DRAM) ? dram_wstrb : iram_wstrb;
  assign mem_addr    = (w_gnt == MST_DRAM) ? dram_addr  : iram_addr;
  assign mem_wdata   = (w_gnt == MST_DRAM) ? dram_wdata : iram_wdata;

  // Reads need a free tag slot; writes never return a response so never wait.
  assign mem_req    = rst_b && w_sel_req && (w_sel_write || !w_fifo_full);
  assign w_xfer     = mem_req && mem_ready;
  assign iram_ready = w_xfer && (w_gnt == MST_IRAM);
  assign dram_ready = w_xfer && (w_gnt == MST_DRAM);

  assign w_push      = w_xfer && !w_sel_write;
  assign w_pop       = rst_b && mem_rvalid && !w_fifo_empty;
  assign iram_rvalid = w_pop && (w_head == MST_IRAM);
  assign dram_rvalid = w_pop && (w_head == MST_DRAM);
  assign iram_rdata  = mem_rdata;
  assign dram_rdata  = mem_rdata;
  assign err_rvalid  = r_err;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_lock     <= 1'b0;
      r_lock_mst <= MST_DRAM;
      r_err      <= 1'b0;
    end else begin
      r_lock     <= mem_req && !mem_ready;
      r_lock_mst <= w_gnt;
      if (mem_rvalid && w_fifo_empty) r_err <= 1'b1;
    end
  end

  mem_arbiter_tag_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_b (rst_b),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_gnt),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .dout  (w_head)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int OUTSTANDING = 4;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk;
  logic              rst_b;
  logic              iram_req, iram_write, iram_ready, iram_rvalid;
  logic [XLEN/8-1:0] iram_wstrb;
  logic [XLEN-1:0]   iram_addr, iram_wdata, iram_rdata;
  logic              dram_req, dram_write, dram_ready, dram_rvalid;
  logic [XLEN/8-1:0] dram_wstrb;
  logic [XLEN-1:0]   dram_addr, dram_wdata, dram_rdata;
  logic              mem_req, mem_write, mem_ready, mem_rvalid;
  logic [XLEN/8-1:0] mem_wstrb;
  logic [XLEN-1:0]   mem_addr, mem_wdata, mem_rdata;
  logic              err_rvalid;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.OUTSTANDING(OUTSTANDING)) dut (
    .clk(clk), .rst_b(rst_b),
    .iram_req(iram_req), .iram_write(iram_write), .iram_wstrb(iram_wstrb),
    .iram_addr(iram_addr), .iram_wdata(iram_wdata), .iram_ready(iram_ready),
    .iram_rvalid(iram_rvalid), .iram_rdata(iram_rdata),
    .dram_req(dram_req), .dram_write(dram_write), .dram_wstrb(dram_wstrb),
    .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_ready(dram_ready),
    .dram_rvalid(dram_rvalid), .dram_rdata(dram_rdata),
    .mem_req(mem_req), .mem_write(mem_write), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err_rvalid(err_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding-read owners in issue order, sticky error,
  // a stalled grant, and (round-robin builds) whose turn it is on a tie.
  bit              m_q[$];
  bit              m_err, m_lock, m_lock_own, m_prio;
  logic [XLEN-1:0] xfer_log[$];

  always @(negedge clk) begin
    bit own, rq, wr, e_req, e_xfer, e_iv, e_dv, do_pop;
    if (!rst_b) begin
      chk("rst_mem_req", mem_req, 0);
      chk("rst_iram_ready", iram_ready, 0);
      chk("rst_dram_ready", dram_ready, 0);
      chk("rst_iram_rvalid", iram_rvalid, 0);
      chk("rst_dram_rvalid", dram_rvalid, 0);
      m_q.delete();
      m_err = 0; m_lock = 0; m_lock_own = 1; m_prio = 1;
    end else begin
      if (m_lock && (m_lock_own ? dram_req : iram_req)) own = m_lock_own;
      else if (iram_req && dram_req) own = RR ? m_prio : 1'b1;
      else own = dram_req;
      rq     = own ? dram_req : iram_req;
      wr     = own ? dram_write : iram_write;
      e_req  = rq && (wr || m_q.size() < OUTSTANDING);
      e_xfer = e_req && mem_ready;
      chk("m_mem_req", mem_req, e_req);
      chk("m_iram_ready", iram_ready, e_xfer && !own);
      chk("m_dram_ready", dram_ready, e_xfer && own);
      if (e_req) begin
        chk("m_mem_addr", mem_addr, own ? dram_addr : iram_addr);
        chk("m_mem_write", mem_write, wr);
        if (wr) begin
          chk("m_mem_wdata", mem_wdata, own ? dram_wdata : iram_wdata);
          chk("m_mem_wstrb", mem_wstrb, own ? dram_wstrb : iram_wstrb);
        end
      end
      e_iv = 0; e_dv = 0; do_pop = 0;
      if (mem_rvalid && m_q.size() > 0) begin
        do_pop = 1;
        e_iv   = !m_q[0];
        e_dv   = m_q[0];
      end
      chk("m_iram_rvalid", iram_rvalid, e_iv);
      chk("m_dram_rvalid", dram_rvalid, e_dv);
      chk("m_err_rvalid", err_rvalid, m_err);
      chk("m_iram_rdata", iram_rdata, mem_rdata);
      chk("m_dram_rdata", dram_rdata, mem_rdata);
      if (mem_rvalid && m_q.size() == 0) m_err = 1;
      if (do_pop) void'(m_q.pop_front());
      if (e_xfer && !wr) m_q.push_back(own);
      m_lock     = e_req && !mem_ready;
      m_lock_own = own;
      if (e_xfer) m_prio = !own;
    end
    if (rst_b && mem_req && mem_ready) xfer_log.push_back(mem_addr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iram_req = 0; iram_write = 0; iram_wstrb = '0; iram_addr = '0; iram_wdata = '0;
    dram_req = 0; dram_write = 0; dram_wstrb = '0; dram_addr = '0; dram_wdata = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_b = 0;
    step();
    step();
    rst_b = 1;
  endtask

  initial begin
    logic [XLEN-1:0] exp_a;
    idle();
    rst_b = 0;
    step();
    // Inputs asserted during reset must not leak to the outputs.
    dram_req = 1; iram_req = 1; mem_rvalid = 1;
    step();
    do_reset();
    @(negedge clk);
    chk("post_rst_err", err_rvalid, 0);
    chk("post_rst_mem_req", mem_req, 0);
    step();

    // Single iram read, response two cycles after acceptance.
    iram_req = 1; iram_addr = 'h100; mem_ready = 1;
    @(negedge clk);
    chk("rd1_mem_req", mem_req, 1);
    chk("rd1_addr", mem_addr, 'h100);
    chk("rd1_iram_ready", iram_ready, 1);
    step();
    iram_req = 0;
    step();
    mem_rvalid = 1; mem_rdata = 'hDEADBEEF;
    @(negedge clk);
    chk("rd1_iram_rvalid", iram_rvalid, 1);
    chk("rd1_dram_rvalid", dram_rvalid, 0);
    chk("rd1_iram_rdata", iram_rdata, 'hDEADBEEF);
    step();
    mem_rvalid = 0;

    // Both masters write every cycle: arbitration order.
    do_reset();
    xfer_log.delete();
    iram_req = 1; iram_write = 1; iram_addr = 'h100; iram_wdata = 'h1111; iram_wstrb = 'hF;
    dram_req = 1; dram_write = 1; dram_addr = 'h200; dram_wdata = 'h2222; dram_wstrb = 'h3;
    mem_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      step();
    end
    idle();
    chk("arb_count", xfer_log.size(), 4);
    for (int i = 0; i < 4 && i < xfer_log.size(); i++) begin
      exp_a = (RR && (i % 2 == 1)) ? 'h100 : 'h200;
      chk($sformatf("arb_grant%0d", i), xfer_log[i], exp_a);
    end

    // FIFO full: 4 dram reads outstanding block the 5th until a response.
    do_reset();
    dram_req = 1; mem_ready = 1;
    for (int i = 0; i < 4; i++) begin
      dram_addr = 'h200 + 4 * i;
      @(negedge clk);
      chk($sformatf("full_acc%0d", i), dram_ready, 1);
      step();
    end
    dram_addr = 'h210;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("full_mem_req", mem_req, 0);
      chk("full_dram_ready", dram_ready, 0);
      step();
    end
    mem_rvalid = 1; mem_rdata = 'h11111111;
    @(negedge clk);
    chk("full_pop_mem_req", mem_req, 0);
    chk("full_pop_dram_rvalid", dram_rvalid, 1);
    step();
    mem_rvalid = 0;
    @(negedge clk);
    chk("full_5th_ready", dram_ready, 1);
    chk("full_5th_addr", mem_addr, 'h210);
    step();
    idle();

    // Stalled dram write holds payload and grant while iram_req rises.
    do_reset();
    dram_req = 1; dram_write = 1; dram_addr = 'h204; dram_wdata = 'hCAFEF00D; dram_wstrb = 'hF;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin iram_req = 1; iram_addr = 'h104; end
      @(negedge clk);
      chk("stall_addr", mem_addr, 'h204);
      chk("stall_wdata", mem_wdata, 'hCAFEF00D);
      chk("stall_dram_ready", dram_ready, 0);
      step();
    end
    mem_ready = 1;
    @(negedge clk);
    chk("stall_accept", dram_ready, 1);
    step();
    dram_req = 0;
    @(negedge clk);
    chk("stall_then_iram", iram_ready, 1);
    step();
    idle();

    // Stalled iram read keeps its grant when higher-priority dram arrives.
    do_reset();
    iram_req = 1; iram_addr = 'h108;
    step();
    dram_req = 1; dram_write = 1; dram_addr = 'h208;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("lock_addr", mem_addr, 'h108);
      step();
    end
    mem_ready = 1;
    @(negedge clk);
    chk("lock_iram_ready", iram_ready, 1);
    step();
    iram_req = 0;
    @(negedge clk);
    chk("lock_then_dram", dram_ready, 1);
    step();
    idle();

    // Interleaved reads return in issue order.
    do_reset();
    mem_ready = 1;
    iram_req = 1; iram_addr = 'h100; step();
    iram_req = 0; dram_req = 1; dram_addr = 'h200; step();
    dram_req = 0; iram_req = 1; iram_addr = 'h104; step();
    iram_req = 0;
    mem_rvalid = 1;
    mem_rdata = 'hA1; @(negedge clk);
    chk("ord0_iram", iram_rvalid, 1); chk("ord0_data", iram_rdata, 'hA1); step();
    mem_rdata = 'hB2; @(negedge clk);
    chk("ord1_dram", dram_rvalid, 1); chk("ord1_data", dram_rdata, 'hB2); step();
    mem_rdata = 'hC3; @(negedge clk);
    chk("ord2_iram", iram_rvalid, 1); chk("ord2_data", iram_rdata, 'hC3); step();
    mem_rvalid = 0;

    // Stray response sets the sticky error; reset clears it mid-flight.
    do_reset();
    mem_rvalid = 1; mem_rdata = 'h55;
    @(negedge clk);
    chk("stray_no_iram", iram_rvalid, 0);
    chk("stray_no_dram", dram_rvalid, 0);
    step();
    mem_rvalid = 0;
    @(negedge clk);
    chk("stray_err_set", err_rvalid, 1);
    step();
    mem_ready = 1;
    iram_req = 1; iram_addr = 'h100; step();
    iram_req = 0; dram_req = 1; dram_addr = 'h200; step();
    rst_b = 0; mem_rvalid = 1;
    @(negedge clk);
    chk("mid_rst_mem_req", mem_req, 0);
    chk("mid_rst_dram_rvalid", dram_rvalid, 0);
    step();
    rst_b = 1; dram_req = 0; mem_rvalid = 0;
    @(negedge clk);
    chk("mid_rst_err_clr", err_rvalid, 0);
    step();
    mem_rvalid = 1;
    @(negedge clk);
    chk("post_rst_no_iram", iram_rvalid, 0);
    chk("post_rst_no_dram", dram_rvalid, 0);
    step();
    mem_rvalid = 0;
    @(negedge clk);
    chk("post_rst_err_set", err_rvalid, 1);
    step();

    idle();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter OUTSTANDING, default 4, max read responses in flight (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  core clock, all logic rising-edge.
REQ-003 SHALL have port rst_b  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports iram_req/iram_write  input  1 each  instruction-side request / write flag.
REQ-005 SHALL have ports iram_wstrb  input  XLEN/8, iram_addr/iram_wdata  input  XLEN  instruction-side request payload.
REQ-006 SHALL have ports iram_ready/iram_rvalid  output  1 each, iram_rdata  output  XLEN  instruction-side accept / response.
REQ-007 SHALL have dram_req, dram_write, dram_wstrb, dram_addr, dram_wdata, dram_ready, dram_rvalid, dram_rdata with the same directions, widths and meanings as the iram_* ports, for the data side.
REQ-008 SHALL have ports mem_req/mem_write  output  1, mem_wstrb  output  XLEN/8, mem_addr/mem_wdata  output  XLEN  shared RAM request.
REQ-009 SHALL have ports mem_ready/mem_rvalid  input  1, mem_rdata  input  XLEN  shared RAM accept / in-order read response.
REQ-010 SHALL have port err_rvalid  output  1  sticky flag: mem_rvalid arrived with no read outstanding.

Function
REQ-011 SHALL transfer a request when mem_req && mem_ready; writes produce no response, reads produce exactly one mem_rvalid, in order.
REQ-012 SHALL drive mem_* payload from the granted master combinationally (zero added request latency).
REQ-013 SHALL assert a master's ready only when it is granted and mem_ready is high and (for reads) the tag FIFO is not full.
REQ-014 SHALL deassert mem_req when the granted request is a read and the tag FIFO is full; writes are never blocked by FIFO fullness.
REQ-015 SHALL hold the grant (lock register) while mem_req is high and mem_ready is low; grant may change only after a transfer or when the granted master drops req.
REQ-016 SHALL push a 1-bit master tag (0=iram, 1=dram) into a FIFO of depth OUTSTANDING on every accepted read.
REQ-017 SHALL route mem_rvalid/mem_rdata combinationally to the master at FIFO head and pop the head in the same cycle.
REQ-018 SHALL hold iram_rdata/dram_rdata equal to mem_rdata; only the rvalid is steered.
REQ-019 SHALL, on simultaneous push and pop, keep the count unchanged; fullness is from the registered count (a pop does not unblock a push in the same cycle).
REQ-020 SHALL, on mem_rvalid with FIFO empty, drive no master rvalid, not change the count, and set err_rvalid until reset.
REQ-021 SHALL wrap FIFO read/write pointers modulo OUTSTANDING.

Reset
REQ-022 SHALL, while rst_b low at a clock edge, clear FIFO count and pointers, clear grant lock, set priority to dram, clear err_rvalid.
REQ-023 SHALL hold mem_req, iram_ready, dram_ready, iram_rvalid, dram_rvalid at 0 during reset regardless of inputs; in-flight responses are discarded.

Configuration
REQ-024 SHALL, with MEM_ARBITER_ROUND_ROBIN_EN defined, arbitrate round-robin: after each transfer priority passes to the other master; first priority after reset is dram.
REQ-025 SHALL, without MEM_ARBITER_ROUND_ROBIN_EN, use fixed priority dram over iram; no priority register is built.

Structure
REQ-026 SHALL place the master tag enum (MST_IRAM, MST_DRAM) in the shared core package; XLEN comes from config.svh.
REQ-027 SHALL implement the tag FIFO as sub-module mem_arbiter_tag_fifo (push, pop, full, empty, dout).

Verification
REQ-028 SHALL test single iram read addr 0x100, mem_rvalid 2 cycles later with 0xDEADBEEF -> only iram_rvalid pulses, iram_rdata 0xDEADBEEF.
REQ-029 SHALL test both req every cycle, mem_ready=1, round-robin build -> grants alternate dram,iram,dram,iram; fixed build -> dram only.
REQ-030 SHALL test 4 dram reads with no response, then a 5th -> mem_req low, dram_ready low until one mem_rvalid, then 5th accepted next cycle.
REQ-031 SHALL test dram write with mem_ready low 3 cycles while iram_req rises -> address/data stable, grant stays dram until accepted.
REQ-032 SHALL test interleaved reads iram,dram,iram -> responses delivered to iram,dram,iram in order with matching data.
REQ-033 SHALL test mem_rvalid with FIFO empty, then reset mid-flight with 2 reads outstanding -> err_rvalid sets then clears, post-reset rvalid sets err_rvalid and no master sees rvalid.
